// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial control-frame link (transmitter and receiver).
// Frame on the wire: start(1), D5..D0, even parity, stop(0).
package serial_link_pkg;

  localparam int BIT_CLKS_DEFAULT = 8;
  localparam int FRAME_DATA_BITS  = 6;

  // Field positions inside the 6-bit data word {IsPro, IsMaster, RawPls, Option[2:0]}
  localparam int POS_IS_PRO     = 5;
  localparam int POS_IS_MASTER  = 4;
  localparam int POS_RAW_PLS    = 3;
  localparam int POS_OPTION_LSB = 0;
  localparam int OPTION_W       = 3;

  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_even(input logic [FRAME_DATA_BITS-1:0] d, input logic p);
    return ~(^{d, p});
  endfunction

endpackage

// File: rtl/led_stretch.sv
// Retriggerable LED stretcher: output stays on for HOLD_CLKS clocks after the last
// trigger, and unconditionally while hold_i is high. Output is registered.
module led_stretch #(
  parameter int HOLD_CLKS = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_i,
  input  logic hold_i,
  output logic led_o
);

  localparam int CW = $clog2(HOLD_CLKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          led_q, led_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trig_i) begin
      cnt_d = CW'(HOLD_CLKS);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    led_d = (cnt_d != '0) | hold_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Oversampling receiver for the 6-bit serial control frame with parity/stop check,
// link-loss timeout and LED stretchers. Optional SERIAL_RX_GLITCH_FILTER_EN turns every
// bit decision into a 2-of-3 majority around mid-bit (one extra clock of latency).
module serial_frame_rx
  import serial_link_pkg::*;
#(
  parameter int BIT_CLKS      = BIT_CLKS_DEFAULT,
  parameter int TIMEOUT_CLKS  = 4096,
  parameter int LED_HOLD_CLKS = 2000000
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_SerialData,
  output logic       o_rcv_en_n,
  output logic       o_IsPro,
  output logic       o_IsMaster,
  output logic       o_RawPls,
  output logic [2:0] o_Option,
  output logic       o_frame_valid,
  output logic       o_frame_err,
  output logic       o_link_ok,
  output logic [1:0] o_rx_led
);

  localparam int CNT_W = $clog2(BIT_CLKS);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
`ifdef SERIAL_RX_GLITCH_FILTER_EN
  localparam int FILT_DLY = 1;
`else
  localparam int FILT_DLY = 0;
`endif
  // Edge detection costs one clock before START is entered, hence the -1.
  localparam int FIRST_PT = BIT_CLKS / 2 - 1 + FILT_DLY;

  logic sync1_q, sync2_q, prev_q;
  logic rise, sample, tick;

`ifdef SERIAL_RX_GLITCH_FILTER_EN
  logic prev2_q;
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) prev2_q <= 1'b0;
    else          prev2_q <= prev_q;
  end
  assign sample = maj3(prev2_q, prev_q, sync2_q);
`else
  assign sample = sync2_q;
`endif

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_SerialData;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

  rx_state_e                      state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [2:0]                     bit_q, bit_d;
  logic [FRAME_DATA_BITS-1:0]     shift_q, shift_d;
  logic                           par_q, par_d;
  logic                           stop_q, stop_d;
  logic                           done_q, done_d;

  assign tick = (state_q == START) ? (cnt_q == CNT_W'(FIRST_PT))
                                   : (cnt_q == CNT_W'(BIT_CLKS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = START;
          cnt_d   = CNT_W'(1);
        end
      end
      START: begin
        if (tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = (sample == START_LEVEL) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {shift_q[FRAME_DATA_BITS-2:0], sample};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'(FRAME_DATA_BITS - 1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          par_d   = sample;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d   = '0;
          stop_d  = sample;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  // Frame verdict is taken one clock after the stop sample, from the captured bits.
  logic                good, bad, to_fire;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                is_pro_q, is_pro_d, is_master_q, is_master_d, raw_pls_q, raw_pls_d;
  logic [OPTION_W-1:0] option_q, option_d;
  logic                valid_q, valid_d, err_q, err_d, link_q, link_d, rcv_en_n_q;

  assign good    = done_q & parity_even(shift_q, par_q) & (stop_q == STOP_LEVEL);
  assign bad     = done_q & ~good;
  assign to_fire = (to_cnt_q == TO_W'(TIMEOUT_CLKS));

  always_comb begin
    is_pro_d    = is_pro_q;
    is_master_d = is_master_q;
    raw_pls_d   = raw_pls_q;
    option_d    = option_q;
    link_d      = link_q;
    valid_d     = good;
    err_d       = bad;
    to_cnt_d    = to_fire ? to_cnt_q : to_cnt_q + 1'b1;
    if (good) begin
      is_pro_d    = shift_q[POS_IS_PRO];
      is_master_d = shift_q[POS_IS_MASTER];
      raw_pls_d   = shift_q[POS_RAW_PLS];
      option_d    = shift_q[POS_OPTION_LSB +: OPTION_W];
      link_d      = 1'b1;
      to_cnt_d    = '0;
    end else if (to_fire) begin
      // Link lost: stop gate drive, keep the configuration fields.
      raw_pls_d = 1'b0;
      link_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      is_pro_q    <= 1'b0;
      is_master_q <= 1'b0;
      raw_pls_q   <= 1'b0;
      option_q    <= '0;
      link_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      to_cnt_q    <= '0;
      rcv_en_n_q  <= 1'b1;
    end else begin
      is_pro_q    <= is_pro_d;
      is_master_q <= is_master_d;
      raw_pls_q   <= raw_pls_d;
      option_q    <= option_d;
      link_q      <= link_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      to_cnt_q    <= to_cnt_d;
      rcv_en_n_q  <= 1'b0;
    end
  end

  led_stretch #(.HOLD_CLKS(LED_HOLD_CLKS)) u_led_good (
    .clk    (i_clk),
    .rst_n  (i_res_n),
    .trig_i (valid_q),
    .hold_i (1'b0),
    .led_o  (o_rx_led[0])
  );

  led_stretch #(.HOLD_CLKS(LED_HOLD_CLKS)) u_led_bad (
    .clk    (i_clk),
    .rst_n  (i_res_n),
    .trig_i (err_q),
    .hold_i (~link_q),
    .led_o  (o_rx_led[1])
  );

  assign o_rcv_en_n    = rcv_en_n_q;
  assign o_IsPro       = is_pro_q;
  assign o_IsMaster    = is_master_q;
  assign o_RawPls      = raw_pls_q;
  assign o_Option      = option_q;
  assign o_frame_valid = valid_q;
  assign o_frame_err   = err_q;
  assign o_link_ok     = link_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed test-plan frames plus randomized
// frames scored against a frame-level model (expected event word and cycle per frame).
module tb_serial_frame_rx;

  localparam int BIT  = 8;
  localparam int TO   = 4096;
  localparam int HOLD = 300;
`ifdef SERIAL_RX_GLITCH_FILTER_EN
  localparam int LAT = 2 + BIT / 2 + 8 * BIT + 1 + 1;
`else
  localparam int LAT = 2 + BIT / 2 + 8 * BIT + 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line;
  logic       o_rcv_en_n, o_IsPro, o_IsMaster, o_RawPls;
  logic [2:0] o_Option;
  logic       o_frame_valid, o_frame_err, o_link_ok;
  logic [1:0] o_rx_led;

  serial_frame_rx #(
    .BIT_CLKS      (BIT),
    .TIMEOUT_CLKS  (TO),
    .LED_HOLD_CLKS (HOLD)
  ) dut (
    .i_clk         (clk),
    .i_res_n       (rst_n),
    .i_SerialData  (line),
    .o_rcv_en_n    (o_rcv_en_n),
    .o_IsPro       (o_IsPro),
    .o_IsMaster    (o_IsMaster),
    .o_RawPls      (o_RawPls),
    .o_Option      (o_Option),
    .o_frame_valid (o_frame_valid),
    .o_frame_err   (o_frame_err),
    .o_link_ok     (o_link_ok),
    .o_rx_led      (o_rx_led)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  // Event word: {valid, err, IsPro, IsMaster, RawPls, Option[2:0], link_ok}
  logic [9:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [5:0] exp_f    = '0;
  logic       exp_link = 1'b0;
  int         last_good = 0;
  int         ev_cnt = 0;
  logic [9:0] mon_exp;
  int         mon_cyc;

  always @(negedge clk) begin
    if (rst_n && (o_frame_valid || o_frame_err)) begin
      ev_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {o_frame_valid, o_frame_err}, 2'b00);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        chk("event_word", {o_frame_valid, o_frame_err, o_IsPro, o_IsMaster, o_RawPls,
                           o_Option, o_link_ok}, mon_exp);
        chk("event_cycle", cyc, mon_cyc);
      end
    end
  end

  // ---------------- drivers ----------------
  // All drivers start and end at posedge+1.
  task automatic idle(input int n);
    line = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [5:0] d, input logic par, input logic stop,
                           input int abort_bit, input int inv_bit);
    logic [8:0] b;
    b = {1'b1, d, par, stop};
    for (int k = 0; k < 9; k++) begin
      if (k == abort_bit) begin
        line = 1'b0;
        return;
      end
      for (int c = 0; c < BIT; c++) begin
        line = (k == inv_bit && c == BIT / 2 - 1) ? ~b[8-k] : b[8-k];
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic frame(input logic [5:0] d, input logic par, input logic stop, input int inv_bit);
    logic good;
    good = ((^{d, par}) == 1'b0) && (stop == 1'b0);
    if (good) begin
      exp_q.push_back({2'b10, d, 1'b1});
      exp_f     = d;
      exp_link  = 1'b1;
      last_good = cyc + LAT;
    end else begin
      exp_q.push_back({2'b01, exp_f, exp_link});
    end
    exp_cyc_q.push_back(cyc + LAT);
    send_bits(d, par, stop, -1, inv_bit);
  endtask

  task automatic wait_until(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // ---------------- stimulus ----------------
  int         ev_before;
  logic [5:0] rd;
  logic       rpar, rstop;

  initial begin
    rst_n = 1'b0;
    line  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rcv_en_n", o_rcv_en_n, 1'b1);
    chk("reset_outputs", {o_IsPro, o_IsMaster, o_RawPls, o_Option, o_frame_valid,
                          o_frame_err, o_link_ok, o_rx_led}, 11'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rcv_en_first", o_rcv_en_n, 1'b1);
    @(negedge clk);
    chk("rcv_en_on", o_rcv_en_n, 1'b0);
    @(posedge clk);
    #1;
    idle(5);

    // Test-plan frame {0,1,1,010}, parity 1
    frame(6'b011010, 1'b1, 1'b0, -1);
    idle(3);
    chk("plan_is_master", o_IsMaster, 1'b1);
    chk("plan_raw_pls", o_RawPls, 1'b1);
    chk("plan_option", o_Option, 3'b010);
    chk("plan_link_ok", o_link_ok, 1'b1);
    chk("plan_led_good", o_rx_led[0], 1'b1);
    chk("plan_led_bad", o_rx_led[1], 1'b0);

    // Same frame, parity forced 0
    frame(6'b011010, 1'b0, 1'b0, -1);
    idle(3);
    chk("perr_option_hold", o_Option, 3'b010);
    chk("perr_raw_hold", o_RawPls, 1'b1);
    chk("perr_led_bad", o_rx_led[1], 1'b1);

    // One-clock glitch on idle line
    ev_before = ev_cnt;
    line = 1'b1;
    @(posedge clk);
    #1;
    idle(40);
    chk("glitch_no_event", ev_cnt, ev_before);

    // Reset at the 4th data bit, then a normal frame
    chk("abort_pending", exp_q.size(), 0);
    ev_before = ev_cnt;
    send_bits(6'b110101, 1'b0, 1'b0, 4, -1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_reset_outputs", {o_IsPro, o_IsMaster, o_RawPls, o_Option, o_frame_valid,
                                o_frame_err, o_link_ok}, 9'h0);
    @(posedge clk);
    #1;
    idle(3);
    rst_n    = 1'b1;
    exp_f    = '0;
    exp_link = 1'b0;
    idle(100);
    chk("abort_no_event", ev_cnt, ev_before);
    frame(6'b100111, 1'b0, 1'b0, -1);
    idle(3);
    chk("after_abort_option", o_Option, 3'b111);
    chk("after_abort_is_pro", o_IsPro, 1'b1);

    // Randomized frames, including back-to-back and corrupted parity/stop
    for (int i = 0; i < 24; i++) begin
      rd    = 6'($urandom_range(0, 63));
      rpar  = (^rd) ^ ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 5) == 0);
      frame(rd, rpar, rstop, -1);
      idle(rstop ? int'($urandom_range(2, 6)) : int'($urandom_range(0, 4)));
    end
    idle(3);
    chk("random_pending", exp_q.size(), 0);

`ifdef SERIAL_RX_GLITCH_FILTER_EN
    // One-clock inversion at mid-bit of D3 must be voted out
    frame(6'b101001, 1'b1, 1'b0, 3);
    idle(3);
    chk("filter_option", o_Option, 3'b001);
    chk("filter_raw", o_RawPls, 1'b1);
`endif

    // Link-loss timeout
    frame(6'b101101, 1'b0, 1'b0, -1);
    wait_until(last_good + TO);
    chk("to_link_before", o_link_ok, 1'b1);
    chk("to_raw_before", o_RawPls, 1'b1);
    wait_until(last_good + TO + 1);
    chk("to_link_after", o_link_ok, 1'b0);
    chk("to_raw_after", o_RawPls, 1'b0);
    chk("to_option_hold", o_Option, 3'b101);
    chk("to_is_pro_hold", o_IsPro, 1'b1);
    wait_until(last_good + TO + 4);
    chk("to_led_bad", o_rx_led[1], 1'b1);
    chk("to_led_good_expired", o_rx_led[0], 1'b0);
    exp_f[3] = 1'b0;
    exp_link = 1'b0;
    @(posedge clk);
    #1;
    frame(6'b011100, 1'b1, 1'b0, -1);
    idle(3);
    chk("restore_link", o_link_ok, 1'b1);
    chk("restore_raw", o_RawPls, 1'b1);
    chk("final_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
